// File: rtl/ntt_core.sv
// Two-dimensional NTT engine: column transforms of A into scratch B, then row
// transforms of B back into A, using one modular MAC driven by running powers.
module ntt_core #(
    parameter int ROWS = 85,
    parameter int COLS = 257,
    parameter int W    = 32,
    parameter logic [3*W-1:0] PARAM_ROM [64] = '{default: '0}
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [5:0]        mod_idx_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [8*COLS-1:0] mem_addr_i,
    input  logic [W*COLS-1:0] din_i,
    output logic [W*COLS-1:0] dout_o,
    output logic              done_o
);

    localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int IW   = $clog2(MAXD + 1);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    typedef enum logic [2:0] {IDLE, SETUP, COL, ROW, FIN, DONE} state_t;

    state_t state_q, state_d;

    logic [W-1:0] memA [ROWS][COLS];
    logic [W-1:0] memB [ROWS][COLS];

    logic [W-1:0]      q_q, q_d, wCol_q, wCol_d, wRow_q, wRow_d;
    logic [W-1:0]      acc_q, acc_d, p_q, p_d, t_q, t_d;
    logic [IW-1:0]     outer_q, outer_d, k_q, k_d, j_q, j_d;
    logic              done_q, done_d;
    logic [W*COLS-1:0] dout_q, dout_d;

    logic          hostAccess, inRow, writeback, lastK, lastOuter, resWrite;
    logic [IW-1:0] lenN;
    logic [RW-1:0] rdRow, wrRow;
    logic [CW-1:0] rdCol, wrCol;
    logic [W-1:0]  macIn, mulOpA, mulOpB, accIn, wCur, macRes, pRes;
    logic [2*W-1:0] qExt, macSum;

    assign hostAccess = (state_q == IDLE) || (state_q == DONE);
    assign inRow      = (state_q == ROW);
    assign lenN       = inRow ? IW'(COLS) : IW'(ROWS);
    assign writeback  = (j_q == lenN);
    assign lastK      = (k_q == lenN - IW'(1));
    assign lastOuter  = (outer_q == (inRow ? IW'(ROWS - 1) : IW'(COLS - 1)));
    assign resWrite   = ((state_q == COL) || (state_q == ROW)) && writeback;

    // COL walks A[j][c] into B[k][c]; ROW walks B[r][j] into A[r][k].
    assign rdRow = inRow ? outer_q[RW-1:0] : j_q[RW-1:0];
    assign rdCol = inRow ? j_q[CW-1:0]     : outer_q[CW-1:0];
    assign wrRow = inRow ? outer_q[RW-1:0] : k_q[RW-1:0];
    assign wrCol = inRow ? k_q[CW-1:0]     : outer_q[CW-1:0];
    assign macIn = inRow ? memB[rdRow][rdCol] : memA[rdRow][rdCol];

    // The writeback cycle borrows the MAC multiplier to advance t by one root step.
    assign wCur   = inRow ? wRow_q : wCol_q;
    assign mulOpA = writeback ? t_q : macIn;
    assign mulOpB = writeback ? wCur : p_q;
    assign accIn  = writeback ? '0 : acc_q;
    assign qExt   = {{W{1'b0}}, q_q};
    assign macSum = {{W{1'b0}}, accIn} + {{W{1'b0}}, mulOpA} * {{W{1'b0}}, mulOpB};
    assign macRes = W'(macSum % qExt);
    assign pRes   = W'(({{W{1'b0}}, p_q} * {{W{1'b0}}, t_q}) % qExt);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        wCol_d  = wCol_q;
        wRow_d  = wRow_q;
        acc_d   = acc_q;
        p_d     = p_q;
        t_d     = t_q;
        outer_d = outer_q;
        k_d     = k_q;
        j_d     = j_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = SETUP;
                    done_d  = 1'b0;
                    q_d     = PARAM_ROM[mod_idx_i][3*W-1:2*W];
                    wCol_d  = PARAM_ROM[mod_idx_i][2*W-1:W];
                    wRow_d  = PARAM_ROM[mod_idx_i][W-1:0];
                end
            end
            SETUP: begin
                state_d = COL;
                outer_d = '0;
                k_d     = '0;
                j_d     = '0;
                acc_d   = '0;
                p_d     = W'(1);
                t_d     = W'(1);
            end
            COL, ROW: begin
                if (!writeback) begin
                    acc_d = macRes;
                    p_d   = pRes;
                    j_d   = j_q + IW'(1);
                end else begin
                    acc_d = '0;
                    p_d   = W'(1);
                    j_d   = '0;
                    if (!lastK) begin
                        k_d = k_q + IW'(1);
                        t_d = macRes;
                    end else begin
                        k_d = '0;
                        t_d = W'(1);
                        if (!lastOuter) begin
                            outer_d = outer_q + IW'(1);
                        end else begin
                            outer_d = '0;
                            state_d = (state_q == COL) ? ROW : FIN;
                        end
                    end
                end
            end
            FIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        if (hostAccess && mem_read_i) begin
            for (int c = 0; c < COLS; c++) begin
                if (mem_addr_i[8*c +: 8] < 8'(ROWS)) begin
                    dout_d[W*c +: W] = memA[mem_addr_i[8*c +: RW]][CW'(c)];
                end else begin
                    dout_d[W*c +: W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            q_q     <= '0;
            wCol_q  <= '0;
            wRow_q  <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            t_q     <= '0;
            outer_q <= '0;
            k_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            wCol_q  <= wCol_d;
            wRow_q  <= wRow_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            t_q     <= t_d;
            outer_q <= outer_d;
            k_q     <= k_d;
            j_q     <= j_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    // Array contents survive reset; host and engine writes never share a state.
    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            if (hostAccess && mem_write_i) begin
                for (int c = 0; c < COLS; c++) begin
                    if (mem_addr_i[8*c +: 8] < 8'(ROWS)) begin
                        memA[mem_addr_i[8*c +: RW]][CW'(c)] <= din_i[W*c +: W];
                    end
                end
            end
            if (resWrite && inRow) begin
                memA[wrRow][wrCol] <= acc_q;
            end
            if (resWrite && !inRow) begin
                memB[wrRow][wrCol] <= acc_q;
            end
        end
    end

    assign dout_o = dout_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_ntt_core.sv
// Self-checking bench for ntt_core at a reduced 5x17 size with a scoreboard
// of expected read vectors and an independent direct-power 2-D NTT model.
module tb_ntt_core;

    localparam int ROWS = 5;
    localparam int COLS = 17;
    localparam int W    = 32;
    localparam int LAT  = COLS*ROWS*(ROWS+1) + ROWS*COLS*(COLS+1) + 2;

    // Entry 1: q=1021 with true 5th/17th roots; entry 2: near-2^32 modulus for wide products.
    localparam logic [3*W-1:0] ROM [64] = '{
        0: {32'd1021, 32'd589, 32'd729},
        1: {32'd1021, 32'd589, 32'd729},
        2: {32'd4294967291, 32'd3123456789, 32'd2987654321},
        default: '0
    };

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              start_i;
    logic [5:0]        mod_idx_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [8*COLS-1:0] mem_addr_i;
    logic [W*COLS-1:0] din_i;
    logic [W*COLS-1:0] dout_o;
    logic              done_o;

    int vectorsApplied = 0;
    int miscompares    = 0;

    longint unsigned modelA [ROWS][COLS];
    longint unsigned stage  [ROWS][COLS];
    logic [W*COLS-1:0] expQ [$];

    ntt_core #(.ROWS(ROWS), .COLS(COLS), .W(W), .PARAM_ROM(ROM)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .start_i    (start_i),
        .mod_idx_i  (mod_idx_i),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .mem_addr_i (mem_addr_i),
        .din_i      (din_i),
        .dout_o     (dout_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8*COLS-1:0] rowAddr(input int r);
        logic [8*COLS-1:0] v;
        for (int c = 0; c < COLS; c++) v[8*c +: 8] = 8'(r);
        return v;
    endfunction

    function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned q);
        return (a * b) % q;
    endfunction

    function automatic longint unsigned powmod(input longint unsigned b, input int e, input longint unsigned q);
        longint unsigned r = 1;
        longint unsigned s = b % q;
        for (int n = e; n > 0; n = n >> 1) begin
            if (n[0]) r = mulmod(r, s, q);
            s = mulmod(s, s, q);
        end
        return r;
    endfunction

    task automatic goldenTransform(input int idx);
        longint unsigned q, wc, wr, acc;
        longint unsigned tmp [ROWS][COLS];
        q  = 64'(ROM[6'(idx)][3*W-1:2*W]);
        wc = 64'(ROM[6'(idx)][2*W-1:W]);
        wr = 64'(ROM[6'(idx)][W-1:0]);
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < ROWS; k++) begin
                acc = 0;
                for (int j = 0; j < ROWS; j++)
                    acc = (acc + mulmod(modelA[j][c] % q, powmod(wc, j*k, q), q)) % q;
                tmp[k][c] = acc;
            end
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                acc = 0;
                for (int j = 0; j < COLS; j++)
                    acc = (acc + mulmod(tmp[r][j], powmod(wr, j*k, q), q)) % q;
                modelA[r][k] = acc;
            end
    endtask

    task automatic applyStimulus(input logic [8*COLS-1:0] addrV, input logic [W*COLS-1:0] dataV);
        int a;
        @(negedge clk_i);
        mem_addr_i  = addrV;
        din_i       = dataV;
        mem_write_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_write_i = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            a = int'(addrV[8*c +: 8]);
            if (a < ROWS) modelA[a][c] = 64'(dataV[W*c +: W]);
        end
    endtask

    task automatic readCheck(input logic [8*COLS-1:0] addrV, input string tag);
        logic [W*COLS-1:0] expV, got;
        int a;
        for (int c = 0; c < COLS; c++) begin
            a = int'(addrV[8*c +: 8]);
            expV[W*c +: W] = (a < ROWS) ? W'(modelA[a][c]) : '0;
        end
        expQ.push_back(expV);
        @(negedge clk_i);
        mem_addr_i = addrV;
        mem_read_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_read_i = 1'b0;
        got  = dout_o;
        expV = expQ.pop_front();
        for (int c = 0; c < COLS; c++)
            checkOutput($sformatf("%s.lane%0d", tag, c), 64'(got[W*c +: W]), 64'(expV[W*c +: W]));
    endtask

    task automatic loadStage();
        logic [W*COLS-1:0] dataV;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) dataV[W*c +: W] = W'(stage[r][c]);
            applyStimulus(rowAddr(r), dataV);
        end
    endtask

    task automatic readAll(input string tag);
        for (int r = 0; r < ROWS; r++) readCheck(rowAddr(r), $sformatf("%s.r%0d", tag, r));
    endtask

    task automatic fillRandom(input longint unsigned q);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) stage[r][c] = 64'($urandom) % q;
    endtask

    // Busy-time injection at cycle 50 must not disturb the run, its result or dout.
    task automatic runTransform(input int idx, input bit inject, input int wrRow);
        int cyc;
        longint unsigned q;
        logic [W*COLS-1:0] heldDout, dataV;
        q = 64'(ROM[6'(idx)][3*W-1:2*W]);
        @(negedge clk_i);
        start_i   = 1'b1;
        mod_idx_i = 6'(idx);
        if (wrRow >= 0) begin
            for (int c = 0; c < COLS; c++) begin
                dataV[W*c +: W] = W'(64'($urandom) % q);
                modelA[wrRow][c] = 64'(dataV[W*c +: W]);
            end
            mem_addr_i  = rowAddr(wrRow);
            din_i       = dataV;
            mem_write_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        mem_write_i = 1'b0;
        goldenTransform(idx);
        checkOutput("doneClear", 64'(done_o), 64'd0);
        heldDout = dout_o;
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 2*LAT) begin
            if (inject && cyc == 50) begin
                start_i     = 1'b1;
                mod_idx_i   = 6'd2;
                mem_write_i = 1'b1;
                mem_read_i  = 1'b1;
                mem_addr_i  = rowAddr(0);
                din_i       = {COLS{32'h5a5a5a5a}};
            end else if (inject && cyc == 51) begin
                start_i     = 1'b0;
                mem_write_i = 1'b0;
                mem_read_i  = 1'b0;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        checkOutput("doneLatency", 64'(cyc), 64'(LAT));
        if (inject) checkOutput("busyReadHeld", 64'(dout_o == heldDout), 64'd1);
    endtask

    initial begin
        logic [8*COLS-1:0] addrV;
        logic [W*COLS-1:0] dataV;
        int cyc;

        reset_ni    = 1'b0;
        start_i     = 1'b0;
        mod_idx_i   = '0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        mem_addr_i  = '0;
        din_i       = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("resetDone", 64'(done_o), 64'd0);
        for (int c = 0; c < COLS; c++)
            checkOutput($sformatf("resetDout.lane%0d", c), 64'(dout_o[W*c +: W]), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        for (int c = 0; c < COLS; c++) dataV[W*c +: W] = W'(c);
        applyStimulus(rowAddr(3), dataV);
        readCheck(rowAddr(3), "row3");

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) stage[r][c] = (r == 0 && c == 0) ? 64'd1 : 64'd0;
        loadStage();

        // Lane 3 points far out of range, lane 4 sits exactly one past the last row.
        addrV = rowAddr(2);
        addrV[8*3 +: 8] = 8'd200;
        addrV[8*4 +: 8] = 8'(ROWS);
        for (int c = 0; c < COLS; c++) dataV[W*c +: W] = W'(32'h100 + c);
        applyStimulus(addrV, dataV);
        readCheck(addrV, "oobRead");
        readCheck(rowAddr(2), "oobRow2");

        loadStage();
        runTransform(1, 1'b0, -1);
        readAll("delta");
        checkOutput("deltaOne", 64'(dout_o[W*(COLS-1) +: W]), 64'd1);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) stage[r][c] = 64'd1;
        loadStage();
        runTransform(1, 1'b0, -1);
        readAll("const");
        readCheck(rowAddr(0), "constRow0");
        checkOutput("constDC", 64'(dout_o[W-1:0]), 64'((ROWS*COLS) % 1021));

        fillRandom(64'd1021);
        loadStage();
        runTransform(1, 1'b1, -1);
        readAll("rand1");

        fillRandom(64'd4294967291);
        loadStage();
        runTransform(2, 1'b0, ROWS-1);
        readAll("rand2");

        fillRandom(64'd1021);
        loadStage();
        readCheck(rowAddr(0), "preAbort");
        @(negedge clk_i);
        start_i   = 1'b1;
        mod_idx_i = 6'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (100) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("abortDone", 64'(done_o), 64'd0);
        for (int c = 0; c < COLS; c++)
            checkOutput($sformatf("abortDout.lane%0d", c), 64'(dout_o[W*c +: W]), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        cyc = 0;
        while (done_o !== 1'b1 && cyc < LAT + 20) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        checkOutput("abortNoDone", 64'(done_o), 64'd0);
        for (int c = 0; c < COLS; c++) dataV[W*c +: W] = W'($urandom);
        applyStimulus(rowAddr(1), dataV);
        readCheck(rowAddr(1), "postAbort");

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
